// File: rtl/uart_pkg.sv
// uart_pkg -- types and helpers shared by the UART receive and transmit sides.
//   rx_state_t  : receive FSM state encoding
//   calc_parity : parity bit for a payload (zero-extend short payloads)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int unsigned MAX_DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W     = 3;

  // Even parity is the XOR of the payload; odd parity is its inverse.
  // Zero-extension of shorter payloads does not change the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// baud_gen -- bit-timing companion for uart_rx_ctrl.
//   clk, rst    : clock and asynchronous active-high reset
//   start_align : count half a bit, then pulse half_tick once
//   en          : pulse tick once every full bit period
//   half_tick   : one-clk pulse half a bit after start_align rose
//   tick        : one-clk pulse per bit period while en = 1
module baud_gen #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic start_align,
  input  logic en,
  output logic half_tick,
  output logic tick
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_reg;

  assign half_tick = start_align && (cnt_reg == CNT_W'(HALF_BIT - 1));
  assign tick      = en && !start_align && (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

  // The counter restarts on every pulse so full-bit ticks land one bit
  // period after the half-bit alignment, i.e. in the middle of each bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      cnt_reg <= '0;
    else if (half_tick || tick || !(start_align || en)) cnt_reg <= '0;
    else                                          cnt_reg <= cnt_reg + CNT_W'(1);
  end

endmodule

// File: rtl/uart_sync2.sv
// uart_sync2 -- two-flop synchronizer for an asynchronous single-bit input.
//   clk : destination clock
//   rst : asynchronous active-high reset, loads both flops with RESET_VAL
//   d   : asynchronous input
//   q   : synchronized output
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= {2{RESET_VAL}};
    else     sync_reg <= {sync_reg[0], d};
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- UART receive controller driven by an external baud_gen.
//   clk, rst            : clock, asynchronous active-high reset
//   rx_serial           : asynchronous line input, idle high
//   rx_half_baud_tick   : half-bit pulse after alignment request
//   rx_baud_tick        : full-bit pulse while rx_en = 1
//   rx_start_align      : asks baud_gen for a half-bit alignment (START)
//   rx_en               : enables full-bit ticks (DATA/PARITY/STOP)
//   rx_data, rx_valid   : received payload with valid/ready handshake
//   rx_ready            : consumer accepts rx_data
//   framing_err, parity_err, overrun_err : sticky error flags
//   err_clr             : synchronous clear of all error flags
//   busy                : FSM is outside IDLE
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  input  logic                 rx_half_baud_tick,
  input  logic                 rx_baud_tick,
  output logic                 rx_start_align,
  output logic                 rx_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  input  logic                 err_clr,
  output logic                 busy
);

  rx_state_t              state_reg, state_next;
  logic                   rxs, rxs_prev_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg;
  logic                   par_bad_reg;
  logic [DATA_BITS-1:0]   rx_data_reg;
  logic                   rx_valid_reg;
  logic                   framing_err_reg, parity_err_reg, overrun_err_reg;

  logic fall_edge, last_bit, stop_sample, frame_good;
  logic set_framing, set_parity, set_overrun, accept, load;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (rxs)
  );

  assign fall_edge   = rxs_prev_reg & ~rxs;
  assign last_bit    = (bit_cnt_reg == BIT_CNT_W'(DATA_BITS - 1));
  assign stop_sample = (state_reg == STOP) && rx_baud_tick;
  assign frame_good  = stop_sample && rxs && !par_bad_reg;
  assign set_framing = stop_sample && !rxs;
  assign set_parity  = stop_sample && rxs && par_bad_reg;
  assign accept      = rx_valid_reg && rx_ready;
  // A completing frame may replace the held one only if it is being
  // consumed in this very clk; otherwise the old frame wins.
  assign load        = frame_good && (!rx_valid_reg || rx_ready);
  assign set_overrun = frame_good && rx_valid_reg && !rx_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; ticks are only looked at in the states that use them
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (fall_edge) state_next = START;
      START:  if (rx_half_baud_tick) state_next = rxs ? IDLE : DATA;
      DATA:   if (rx_baud_tick && last_bit)
                state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (rx_baud_tick) state_next = STOP;
      STOP:   if (rx_baud_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    rx_start_align = 1'b0;
    rx_en          = 1'b0;
    busy           = 1'b1;
    case (state_reg)
      IDLE:               busy           = 1'b0;
      START:              rx_start_align = 1'b1;
      DATA, PARITY, STOP: rx_en          = 1'b1;
      default:            busy           = 1'b0;
    endcase
  end

  // Frame datapath: edge history, shift register, bit counter, parity flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxs_prev_reg <= 1'b1;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      par_bad_reg  <= 1'b0;
    end else begin
      rxs_prev_reg <= rxs;
      case (state_reg)
        START: begin
          bit_cnt_reg <= '0;
          par_bad_reg <= 1'b0;
        end
        DATA: if (rx_baud_tick) begin
          shift_reg   <= {rxs, shift_reg[DATA_BITS-1:1]};
          bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + BIT_CNT_W'(1);
        end
        PARITY: if (rx_baud_tick) begin
          par_bad_reg <= (rxs != calc_parity(MAX_DATA_BITS'(shift_reg),
                                             PARITY_ODD != 0));
        end
        default: ;
      endcase
    end
  end

  // Output holding register, handshake and sticky flags. A new error in
  // the same clk as err_clr survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      framing_err_reg <= 1'b0;
      parity_err_reg  <= 1'b0;
      overrun_err_reg <= 1'b0;
    end else begin
      if (load) begin
        rx_data_reg  <= shift_reg;
        rx_valid_reg <= 1'b1;
      end else if (accept) begin
        rx_valid_reg <= 1'b0;
      end
      framing_err_reg <= (framing_err_reg & ~err_clr) | set_framing;
      parity_err_reg  <= (parity_err_reg  & ~err_clr) | set_parity;
      overrun_err_reg <= (overrun_err_reg & ~err_clr) | set_overrun;
    end
  end

  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign framing_err = framing_err_reg;
  assign parity_err  = parity_err_reg;
  assign overrun_err = overrun_err_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl -- directed bench for uart_rx_ctrl with two instances:
// an 8N1 receiver (_n signals) and an 8E1 receiver (_p signals), each paired
// with its own baud_gen at 50 MHz / 115200 baud.
module tb_uart_rx_ctrl;

  localparam int BIT_CLKS = 434;
  localparam int IDLE_GAP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       rx_n = 1'b1, ready_n = 1'b0, clr_n = 1'b0;
  logic       half_n, tick_n, align_n, en_n, valid_n, fe_n, pe_n, oe_n, busy_n;
  logic [7:0] data_n;

  logic       rx_p = 1'b1, ready_p = 1'b0, clr_p = 1'b0;
  logic       half_p, tick_p, align_p, en_p, valid_p, fe_p, pe_p, oe_p, busy_p;
  logic [7:0] data_p;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_tick = -1;
  int rise_cyc = -1;
  logic valid_n_d = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Remember when the last full-bit tick and the last rx_valid rise happened
  always @(negedge clk) begin
    if (tick_n) last_tick <= cyc;
    if (valid_n && !valid_n_d) rise_cyc <= cyc;
    valid_n_d <= valid_n;
  end

  baud_gen #(.CLK_FREQ(50_000_000), .BAUD(115200)) u_bg_n (
    .clk(clk), .rst(rst), .start_align(align_n), .en(en_n),
    .half_tick(half_n), .tick(tick_n));

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_n (
    .clk(clk), .rst(rst), .rx_serial(rx_n),
    .rx_half_baud_tick(half_n), .rx_baud_tick(tick_n),
    .rx_start_align(align_n), .rx_en(en_n),
    .rx_data(data_n), .rx_valid(valid_n), .rx_ready(ready_n),
    .framing_err(fe_n), .parity_err(pe_n), .overrun_err(oe_n),
    .err_clr(clr_n), .busy(busy_n));

  baud_gen #(.CLK_FREQ(50_000_000), .BAUD(115200)) u_bg_p (
    .clk(clk), .rst(rst), .start_align(align_p), .en(en_p),
    .half_tick(half_p), .tick(tick_p));

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst(rst), .rx_serial(rx_p),
    .rx_half_baud_tick(half_p), .rx_baud_tick(tick_p),
    .rx_start_align(align_p), .rx_en(en_p),
    .rx_data(data_p), .rx_valid(valid_p), .rx_ready(ready_p),
    .framing_err(fe_p), .parity_err(pe_p), .overrun_err(oe_p),
    .err_clr(clr_p), .busy(busy_p));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx_n = v;
  endtask

  task automatic hold_bit(input bit sel, input logic v);
    drive(sel, v);
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic pulse_clr(input bit sel);
    if (sel) clr_p = 1'b1; else clr_n = 1'b1;
    @(negedge clk);
    clr_p = 1'b0;
    clr_n = 1'b0;
  endtask

  task automatic drain_n();
    if (valid_n) begin
      ready_n = 1'b1;
      @(negedge clk);
      ready_n = 1'b0;
    end
  endtask

  // hook: 0 = none, 1 = rx_ready pulse on the stop-bit tick,
  //       2 = err_clr pulse on the stop-bit tick
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                            input logic par, input logic stop, input int hook);
    int n;
    hold_bit(sel, 1'b0);
    for (int b = 0; b < 8; b++) hold_bit(sel, d[b]);
    if (with_par) hold_bit(sel, par);
    drive(sel, stop);
    if (hook != 0) begin
      n = 0;
      @(negedge clk);
      while (!(sel ? tick_p : tick_n) && n < BIT_CLKS) begin
        @(negedge clk);
        n++;
      end
      check("stop_tick_seen", 32'(n < BIT_CLKS), 1);
      if (hook == 1) begin
        if (sel) ready_p = 1'b1; else ready_n = 1'b1;
      end else begin
        if (sel) clr_p = 1'b1; else clr_n = 1'b1;
      end
      @(negedge clk);
      ready_n = 1'b0; ready_p = 1'b0; clr_n = 1'b0; clr_p = 1'b0;
      repeat (BIT_CLKS / 2) @(negedge clk);
    end else begin
      repeat (BIT_CLKS) @(negedge clk);
    end
    drive(sel, 1'b1);
    repeat (IDLE_GAP) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       drain;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_oe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, need $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_cyc;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[5] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[6] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_valid", valid_n, 0);
    check("rst_data", data_n, 0);
    check("rst_busy", busy_n, 0);
    check("rst_align", align_n, 0);
    check("rst_en", en_n, 0);
    check("rst_flags", {fe_n, pe_n, oe_n}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Table-driven 8N1 frames
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].drain) drain_n();
      pulse_clr(1'b0);
      start_cyc = cyc;
      send_frame(1'b0, vecs[i].data, 1'b0, 1'b0, vecs[i].stop, 0);
      check($sformatf("vec%0d_valid", i), valid_n, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), data_n, vecs[i].exp_data);
      check($sformatf("vec%0d_framing", i), fe_n, vecs[i].exp_fe);
      check($sformatf("vec%0d_overrun", i), oe_n, vecs[i].exp_oe);
      check($sformatf("vec%0d_parity", i), pe_n, 0);
      if (vecs[i].exp_valid && vecs[i].drain) begin
        check($sformatf("vec%0d_valid_after_stop_tick", i), rise_cyc, last_tick + 1);
        check($sformatf("vec%0d_frame_latency_ok", i),
              32'((rise_cyc - start_cyc) >= 4000 && (rise_cyc - start_cyc) <= 4340), 1);
      end
    end

    // Accept and completion in the same clk: new frame loads, no overrun
    pulse_clr(1'b0);
    send_frame(1'b0, 8'h96, 1'b0, 1'b0, 1'b1, 1);
    check("simacc_valid", valid_n, 1);
    check("simacc_data", data_n, 8'h96);
    check("simacc_overrun", oe_n, 0);

    // Hold while not ready, then fall one clk after acceptance
    repeat (50) @(negedge clk);
    check("hold_valid", valid_n, 1);
    check("hold_data", data_n, 8'h96);
    ready_n = 1'b1;
    @(negedge clk);
    ready_n = 1'b0;
    check("accept_valid_fall", valid_n, 0);

    // False start: 100-clk low pulse
    rx_n = 1'b0;
    repeat (100) @(negedge clk);
    check("false_busy", busy_n, 1);
    check("false_align", align_n, 1);
    check("false_en", en_n, 0);
    rx_n = 1'b1;
    repeat (300) @(negedge clk);
    check("false_idle", busy_n, 0);
    check("false_valid", valid_n, 0);
    check("false_framing", fe_n, 0);

    // Reset in the middle of a frame (after four data bits)
    hold_bit(1'b0, 1'b0);
    for (int b = 0; b < 4; b++) hold_bit(1'b0, b[0]);
    check("mid_busy", busy_n, 1);
    check("mid_en", en_n, 1);
    check("mid_align", align_n, 0);
    rst = 1'b1;
    rx_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_data", data_n, 0);
    check("midrst_valid", valid_n, 0);
    check("midrst_busy", busy_n, 0);
    check("midrst_en", en_n, 0);
    check("midrst_flags", {fe_n, pe_n, oe_n}, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("postrst_valid", valid_n, 0);
    check("postrst_flags", {fe_n, pe_n, oe_n}, 0);
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 0);
    check("postrst_frame_valid", valid_n, 1);
    check("postrst_frame_data", data_n, 8'h55);

    // Even parity receiver: 0x07 carries parity bit 1
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 0);
    check("par_bad_flag", pe_p, 1);
    check("par_bad_valid", valid_p, 0);
    check("par_bad_framing", fe_p, 0);
    pulse_clr(1'b1);
    check("par_clr", pe_p, 0);
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 2);
    check("par_err_beats_clr", pe_p, 1);
    pulse_clr(1'b1);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 0);
    check("par_good_valid", valid_p, 1);
    check("par_good_data", data_p, 8'h07);
    check("par_good_flag", pe_p, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..8).
REQ-002 SHALL have parameter PARITY_EN, default 0, meaning 1 = one parity bit follows the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0, meaning 1 = odd parity, 0 = even parity.
REQ-004 SHALL have port clk, input, 1 bit, the single clock: all logic on posedge.
REQ-005 SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-006 SHALL have port rx_serial, input, 1 bit, asynchronous UART line, idle high.
REQ-007 SHALL have port rx_half_baud_tick, input, 1 bit, one-clk pulse from the baud generator half a bit after alignment.
REQ-008 SHALL have port rx_baud_tick, input, 1 bit, one-clk pulse from the baud generator every bit period while rx_en = 1.
REQ-009 SHALL have port rx_start_align, output, 1 bit, requests a half-bit alignment from the baud generator.
REQ-010 SHALL have port rx_en, output, 1 bit, enables full-bit ticks.
REQ-011 SHALL have port rx_data, output, DATA_BITS bits, received payload, LSB first on the line.
REQ-012 SHALL have port rx_valid, output, 1 bit, rx_data holds a frame.
REQ-013 SHALL have port rx_ready, input, 1 bit, consumer accepts rx_data.
REQ-014 SHALL have ports framing_err, parity_err and overrun_err, each output, 1 bit, sticky error flags.
REQ-015 SHALL have port err_clr, input, 1 bit, synchronous clear of all error flags.
REQ-016 SHALL have port busy, output, 1 bit, 1 in any state other than IDLE.

Function
REQ-017 rx_serial SHALL pass through a 2-FF synchronizer; all sampling SHALL use the synchronized value (rxs).
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE: a falling edge of rxs (previous 1, current 0) SHALL move the FSM to START on the next clk.
REQ-020 START: rx_start_align SHALL be 1 and rx_en SHALL be 0.
REQ-021 START: on rx_half_baud_tick, rxs = 0 SHALL move the FSM to DATA; rxs = 1 (false start) SHALL return it to IDLE without any flag.
REQ-022 DATA, PARITY and STOP: rx_en SHALL be 1 and rx_start_align SHALL be 0; each state SHALL sample rxs only on rx_baud_tick.
REQ-023 DATA: the FSM SHALL shift rxs into a shift register LSB first and count bits 0..DATA_BITS-1.
REQ-024 DATA: after the last bit, the FSM SHALL go to PARITY if PARITY_EN = 1, otherwise to STOP.
REQ-025 PARITY: the FSM SHALL compare rxs with the XOR of the data bits, inverted when PARITY_ODD = 1; a mismatch SHALL set a per-frame parity flag.
REQ-026 STOP: rxs = 0 SHALL set framing_err and discard the frame.
REQ-027 STOP: rxs = 1 with no parity mismatch SHALL load rx_data and set rx_valid in the same clk.
REQ-028 STOP: rxs = 1 with a parity mismatch SHALL set parity_err and discard the frame.
REQ-029 STOP SHALL always return to IDLE on the next clk.
REQ-030 Latency: rx_valid SHALL rise 1 clk after the stop-bit rx_baud_tick.
REQ-031 Handshake: rx_valid and rx_data SHALL hold until a clk with rx_valid = 1 and rx_ready = 1; rx_valid SHALL fall the following clk.
REQ-032 Overrun: if a frame completes while rx_valid = 1 and rx_ready = 0, the block SHALL set overrun_err and keep the old rx_data.
REQ-033 Simultaneous accept and completion in the same clk SHALL load the new frame, keep rx_valid = 1, and not flag overrun.
REQ-034 Error flags SHALL be sticky until err_clr; err_clr in the same clk as a new error SHALL leave that flag set.
REQ-035 Ticks arriving in states that do not consume them SHALL be ignored.
REQ-036 A new falling edge SHALL be honoured only in IDLE, so back-to-back frames work with exactly one stop bit.

Reset
REQ-037 rst SHALL force state IDLE, synchronizer FFs to 1, shift register and bit counter to 0.
REQ-038 While rst = 1, rx_data SHALL be 0 and rx_valid, rx_start_align, rx_en, busy and all error flags SHALL be 0.
REQ-039 rst asserted mid-frame SHALL abort the frame immediately, with no flag and no rx_valid.

Structure
REQ-040 A package uart_pkg SHALL hold the rx_state_t enum and the parity-compute function.
REQ-041 The package SHALL be shared with the TX side; the synchronizer SHALL be sub-module uart_sync2.
REQ-042 The block SHALL instantiate no baud_gen; it connects to one at the top level.

Verification
REQ-043 Bench SHALL instantiate baud_gen with CLK_FREQ 50_000_000 and BAUD 115200 (434 clk/bit).
REQ-044 Frame 0xA5 (8N1) -> rx_valid after ~4340 clk, rx_data = 8'hA5, no flags.
REQ-045 rx_serial 0 pulse of 100 clk -> false start; FSM returns to IDLE, rx_valid stays 0.
REQ-046 Stop bit driven 0 on 0x3C -> framing_err = 1, rx_valid = 0; err_clr -> flag 0.
REQ-047 PARITY_EN = 1, even, 0x07 sent with parity 0 -> parity_err = 1; with parity 1 -> rx_data = 8'h07.
REQ-048 rx_ready = 0, frames 0x11 then 0x22 -> overrun_err = 1, rx_data = 8'h11.
REQ-049 rst pulsed at bit 4 of a frame -> all outputs 0; the next frame 0x55 is received correctly.
